// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Widths here size the pending entries and the register-file write port.
package wb_arb_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } pend_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_QUEUE
  } grant_e;

endpackage

// File: rtl/wb_pend_queue.sv
// Pending queue for long-latency results: circular buffer with per-entry live
// bits, kill-by-address for WAW ordering, and two-port RAW address match.
module wb_pend_queue
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [REG_AW-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     kill_en,
  input  logic [REG_AW-1:0]        kill_addr,
  input  logic [REG_AW-1:0]        rs_addr,
  input  logic [REG_AW-1:0]        rt_addr,
  output pend_entry_t              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     hit_rs,
  output logic                     hit_rt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;
  logic [REG_AW-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  live_q;

  // NOTE: payload storage has no reset; only live bits and pointers define
  // occupancy, so stale payload is never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_ptr] <= push_addr;
      data_q[tail_ptr] <= push_data;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // later statements below override earlier ones for the same bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      live_q   <= '0;
    end else begin
      // Kill only hits entries already stored; the incoming entry stays live.
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && addr_q[i] == kill_addr) live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[head_ptr] <= 1'b0;
        head_ptr         <= head_ptr + 1'b1;
      end
      if (push) begin
        live_q[tail_ptr] <= 1'b1;
        tail_ptr         <= tail_ptr + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign head  = '{live: live_q[head_ptr], addr: addr_q[head_ptr], data: data_q[head_ptr]};
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // NOTE: every combinationally written signal gets a default first so no
  // latch is inferred.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && addr_q[i] == rs_addr) hit_rs = 1'b1;
      if (live_q[i] && addr_q[i] == rt_addr) hit_rt = 1'b1;
    end
    if (rs_addr == REG_ZERO) hit_rs = 1'b0;
    if (rt_addr == REG_ZERO) hit_rt = 1'b0;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency
// results queue and drain when the port is free. WB_ARB_BYPASS_EN adds a direct path.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   pipe_wr_en,
  input  logic [REG_AW-1:0]      pipe_wr_addr,
  input  logic [DATA_W-1:0]      pipe_wr_data,
  input  logic                   lu_valid,
  input  logic [REG_AW-1:0]      lu_addr,
  input  logic [DATA_W-1:0]      lu_data,
  output logic                   lu_ready,
  input  logic [REG_AW-1:0]      rs_addr,
  input  logic [REG_AW-1:0]      rt_addr,
  output logic                   pend_hazard_rs,
  output logic                   pend_hazard_rt,
  output logic                   stall_req,
  output logic                   rf_we,
  output logic [REG_AW-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic [$clog2(DEPTH):0] pend_cnt,
  output logic                   proto_err
);

  localparam int SW = $clog2(STARVE_MAX) + 1;
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

  grant_e            grant;
  pend_entry_t       q_head;
  logic              q_full, q_empty;
  logic              pipe_go, lu_keep, push, pop, blocked, bypass;
  logic              we_d;
  logic [REG_AW-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [SW-1:0]     starve_cnt;

  assign pipe_go  = pipe_wr_en && (pipe_wr_addr != REG_ZERO);
  assign lu_ready = !q_full;
  // $0 handshakes complete but carry nothing worth writing.
  assign lu_keep  = lu_valid && lu_ready && (lu_addr != REG_ZERO);

  always_comb begin
    grant = GNT_NONE;
    if (pipe_go)       grant = GNT_PIPE;
    else if (!q_empty) grant = GNT_QUEUE;
  end

`ifdef WB_ARB_BYPASS_EN
  assign bypass = (grant == GNT_NONE) && lu_keep;
`else
  assign bypass = 1'b0;
`endif

  assign push    = lu_keep && !bypass;
  assign pop     = (grant == GNT_QUEUE);
  assign blocked = !q_empty && (grant == GNT_PIPE);

  always_comb begin
    we_d    = 1'b0;
    waddr_d = pipe_wr_addr;
    wdata_d = pipe_wr_data;
    case (grant)
      GNT_PIPE:  we_d = 1'b1;
      GNT_QUEUE: begin
        we_d    = q_head.live;
        waddr_d = q_head.addr;
        wdata_d = q_head.data;
      end
      default: begin
        we_d    = bypass;
        waddr_d = lu_addr;
        wdata_d = lu_data;
      end
    endcase
  end

  wb_pend_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_addr (lu_addr),
    .push_data (lu_data),
    .pop       (pop),
    .kill_en   (grant == GNT_PIPE),
    .kill_addr (pipe_wr_addr),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .head      (q_head),
    .count     (pend_cnt),
    .full      (q_full),
    .empty     (q_empty),
    .hit_rs    (pend_hazard_rs),
    .hit_rt    (pend_hazard_rt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
      proto_err  <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      stall_req <= 1'b0;
      if (blocked) begin
        if (starve_cnt == STARVE_LAST) begin
          starve_cnt <= '0;
          stall_req  <= 1'b1;
        end else begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else begin
        starve_cnt <= '0;
      end
      if (pipe_wr_en && stall_req) proto_err <= 1'b1;
      rf_we <= we_d;
      if (we_d) begin
        rf_waddr <= waddr_d;
        rf_wdata <= wdata_d;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic                   clk, rstn;
  logic                   pipe_wr_en, lu_valid, lu_ready;
  logic [REG_AW-1:0]      pipe_wr_addr, lu_addr, rs_addr, rt_addr, rf_waddr;
  logic [DATA_W-1:0]      pipe_wr_data, lu_data, rf_wdata;
  logic                   pend_hazard_rs, pend_hazard_rt, stall_req, rf_we, proto_err;
  logic [$clog2(DEPTH):0] pend_cnt;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rstn(rstn),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_addr(pipe_wr_addr), .pipe_wr_data(pipe_wr_data),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .pend_hazard_rs(pend_hazard_rs), .pend_hazard_rt(pend_hazard_rt),
    .stall_req(stall_req), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_cnt(pend_cnt), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending results in arrival order, plus the values the
  // registered outputs must show after the next edge.
  typedef struct {
    bit        live;
    bit [4:0]  addr;
    bit [31:0] data;
  } ent_t;

  ent_t      mq[$];
  bit        m_we, m_stall, m_proto;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  int        m_run;

  function automatic void model_reset();
    mq.delete();
    m_we = 0; m_waddr = 0; m_wdata = 0;
    m_stall = 0; m_proto = 0; m_run = 0;
  endfunction

  function automatic bit pending_for(bit [4:0] a);
    if (a == 0) return 0;
    foreach (mq[i]) if (mq[i].live && mq[i].addr == a) return 1;
    return 0;
  endfunction

  function automatic void model_step(bit pwe, bit [4:0] pa, bit [31:0] pd,
                                     bit lv, bit [4:0] la, bit [31:0] ld);
    int n    = mq.size();
    bit pipe = pwe && pa != 0;
    bit hs   = lv && n != DEPTH;
    if (pwe && m_stall) m_proto = 1;
    // A bubble is owed after STARVE_MAX consecutive cycles of the pipe
    // holding the port while something waits.
    m_stall = 0;
    if (n > 0 && pipe) begin
      m_run++;
      if (m_run == STARVE_MAX) begin
        m_stall = 1;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    m_we = 0;
    if (pipe) begin
      m_we = 1; m_waddr = pa; m_wdata = pd;
      foreach (mq[i]) if (mq[i].addr == pa) mq[i].live = 0;
    end else if (n > 0) begin
      ent_t h = mq.pop_front();
      m_we = h.live;
      if (h.live) begin
        m_waddr = h.addr; m_wdata = h.data;
      end
    end
`ifdef WB_ARB_BYPASS_EN
    else if (hs && la != 0) begin
      m_we = 1; m_waddr = la; m_wdata = ld;
      hs = 0;
    end
`endif
    if (hs && la != 0) mq.push_back('{live: 1'b1, addr: la, data: ld});
  endfunction

  task automatic check_state(input string pfx, input bit [4:0] rs, input bit [4:0] rt);
    check({pfx, "_lu_ready"}, lu_ready, mq.size() != DEPTH);
    check({pfx, "_pend_cnt"}, pend_cnt, mq.size());
    check({pfx, "_haz_rs"}, pend_hazard_rs, pending_for(rs));
    check({pfx, "_haz_rt"}, pend_hazard_rt, pending_for(rt));
    check({pfx, "_rf_we"}, rf_we, m_we);
    if (m_we) begin
      check({pfx, "_rf_waddr"}, rf_waddr, m_waddr);
      check({pfx, "_rf_wdata"}, rf_wdata, m_wdata);
    end
    check({pfx, "_stall"}, stall_req, m_stall);
    check({pfx, "_proto"}, proto_err, m_proto);
  endtask

  // One clock of stimulus: drive after the falling edge, check the DUT
  // against the model, then advance the model across the coming rising edge.
  task automatic cycle(input string pfx,
                       input bit pwe, input bit [4:0] pa, input bit [31:0] pd,
                       input bit lv, input bit [4:0] la, input bit [31:0] ld,
                       input bit [4:0] rs, input bit [4:0] rt, input bit honour = 1);
    @(negedge clk);
    if (honour && m_stall) pwe = 0;
    pipe_wr_en = pwe; pipe_wr_addr = pa; pipe_wr_data = pd;
    lu_valid = lv; lu_addr = la; lu_data = ld;
    rs_addr = rs; rt_addr = rt;
    #1;
    check_state(pfx, rs, rt);
    model_step(pwe, pa, pd, lv, la, ld);
  endtask

  task automatic idle(input string pfx, input bit [4:0] rs = 0);
    cycle(pfx, 0, 0, 0, 0, 0, 0, rs, 0);
  endtask

  initial begin
    int pct;
    rstn = 1'b0;
    pipe_wr_en = 0; pipe_wr_addr = 0; pipe_wr_data = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0; rs_addr = 0; rt_addr = 0;
    model_reset();
    #12;
    check_state("rst", 0, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Single lu result with the pipe idle.
    cycle("d1", 0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
`ifndef WB_ARB_BYPASS_EN
    idle("d1b", 5);
`endif
    @(posedge clk); #1;
    check("d1_we", rf_we, 1);
    check("d1_waddr", rf_waddr, 5);
    check("d1_wdata", rf_wdata, 32'hDEADBEEF);
    check("d1_cnt", pend_cnt, 0);

    // Pipe and lu in the same cycle: pipe first, lu the edge after.
    cycle("d2", 1, 3, 32'h11, 1, 4, 32'h22, 4, 3);
    @(posedge clk); #1;
    check("d2_pipe_addr", rf_waddr, 3);
    idle("d2b", 4);
    @(posedge clk); #1;
    check("d2_lu_addr", rf_waddr, 4);
    check("d2_lu_data", rf_wdata, 32'h22);

    // WAW kill: the queued $7 must never reach the register file.
    cycle("d3", 0, 0, 0, 1, 7, 32'hAA, 7, 0);
    cycle("d3b", 1, 7, 32'hBB, 0, 0, 0, 7, 7);
    idle("d3c", 7);
    idle("d3d", 7);
    idle("d3e", 7);

    // $0 traffic on both paths.
    cycle("d4", 1, 0, 32'h55, 1, 0, 32'h66, 0, 0);
    cycle("d4b", 1, 0, 32'h57, 1, 0, 32'h67, 0, 0);
    idle("d4c");

    // Fill while the pipe owns the port, then let starvation force a bubble.
    for (int i = 0; i < 5; i++) cycle("d5f", 1, 9, i, 1, 5'(i + 1), 32'h100 + i, 5'(i + 1), 0);
    for (int k = 0; k < 3 * STARVE_MAX && !m_stall; k++) cycle("d5s", 1, 9, 32'h200 + k, 0, 0, 0, 1, 2);
    check("d5_bubble_due", m_stall, 1);
    cycle("d5p", 1, 9, 32'h300, 0, 0, 0, 2, 3);

    // Break the contract once, then reset with entries still queued.
    for (int k = 0; k < 3 * STARVE_MAX && !m_stall; k++) cycle("d6s", 1, 10, 32'h400 + k, 0, 0, 0, 3, 4);
    cycle("d6v", 1, 11, 32'h500, 0, 0, 0, 3, 4, 0);
    cycle("d6x", 1, 12, 32'h501, 1, 6, 32'h600, 3, 6);
    @(negedge clk);
    pipe_wr_en = 0; lu_valid = 0; rs_addr = 3; rt_addr = 4;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_state("r2", 3, 4);
    check("r2_waddr", rf_waddr, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) idle("r2i", 3);

    // Random traffic with varying pipe pressure.
    for (int it = 0; it < 2000; it++) begin
      case (it / 400)
        0: pct = 20;
        1: pct = 50;
        2: pct = 95;
        3: pct = 100;
        default: pct = 60;
      endcase
      cycle("rnd",
            $urandom_range(99) < pct, 5'($urandom_range(7)), $urandom,
            $urandom_range(1), 5'($urandom_range(7)), $urandom,
            5'($urandom_range(7)), 5'($urandom_range(7)));
    end
    for (int k = 0; k < DEPTH + 2; k++) idle("drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
